// File: rtl/hub75_capture.sv
// hub75_capture: HUB75 panel bus receiver that rebuilds latched row pairs as a pixel stream
module hub75_capture #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int XW        = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           hub_rgb0,
    input  logic [2:0]           hub_rgb1,
    input  logic [ADDR_BITS-1:0] hub_addr,
    input  logic                 hub_blank,
    input  logic                 hub_latch,
    input  logic                 hub_sclk,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [XW-1:0]        pix_x,
    output logic [ADDR_BITS:0]   pix_y,
    output logic [2:0]           pix_rgb,
    output logic                 row_done,
    output logic                 blank_level,
    output logic                 err_len,
    output logic                 err_overrun,
    input  logic                 err_clear
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int SW = 9 + ADDR_BITS;
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] SAT  = CW'(WIDTH + 1);
    localparam logic [XW-1:0] LAST = XW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, TOP, BOT} state_t;

    logic [SW-1:0]        s1, s2;
    logic [1:0]           s3;
    logic [2:0]           rgb0, rgb1;
    logic [ADDR_BITS-1:0] addr, row_addr;
    logic                 latch_rise, sclk_rise, idle, handoff, wr, beat, last;
    logic [CW-1:0]        count;
    logic [XW-1:0]        wcol, x, x_n;
    logic [2:0]           cap0 [WIDTH];
    logic [2:0]           cap1 [WIDTH];
    logic [2:0]           em0 [WIDTH];
    logic [2:0]           em1 [WIDTH];
    state_t               state, state_n;
    logic                 done_n;

    assign {rgb0, rgb1, addr} = s2[SW-1:3];
    assign blank_level = s2[2];
    assign latch_rise  = s2[1] & ~s3[1];
    assign sclk_rise   = s2[0] & ~s3[0];
    assign idle        = state == IDLE;
    assign handoff     = latch_rise && count == FULL && idle;
    assign wr          = sclk_rise && (latch_rise || count < FULL);
    assign wcol        = latch_rise ? LAST : LAST - count[XW-1:0];
    assign beat        = pix_valid && pix_ready;
    assign last        = x == LAST;
    assign pix_valid   = !idle;
    assign pix_x       = x;
    assign pix_y       = idle ? '0 : {state == BOT, row_addr};
    assign pix_rgb     = idle ? 3'b000 : (state == BOT ? em1[x] : em0[x]);

    // Two-flop synchronizer on the whole bus plus a third stage on latch/sclk for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {hub_rgb0, hub_rgb1, hub_addr, hub_blank, hub_latch, hub_sclk};
            s2 <= s1;
            s3 <= s2[1:0];
        end
    end

    // Shift counter; a latch restarts the row and a coincident shift becomes its first pixel
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (latch_rise)
            count <= sclk_rise ? CW'(1) : '0;
        else if (sclk_rise && count != SAT)
            count <= count + 1'b1;
    end

    // Capture writes fill from the far column inward; a complete row is copied to the emit buffer
    always_ff @(posedge clk) begin
        if (wr) begin
            cap0[wcol] <= rgb0;
            cap1[wcol] <= rgb1;
        end
        if (handoff) begin
            em0      <= cap0;
            em1      <= cap1;
            row_addr <= addr;
        end
    end

    // Sticky errors; a new error event overrides a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_len     <= (latch_rise && count != FULL) || (err_len && !err_clear);
            err_overrun <= (latch_rise && count == FULL && !idle) || (err_overrun && !err_clear);
        end
    end

    // Emitter state, column and row_done registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            x        <= '0;
            row_done <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            row_done <= done_n;
        end
    end

    // Emitter next state: top half then bottom half, advancing only on accepted beats
    always_comb begin
        state_n = state;
        x_n     = x;
        done_n  = 1'b0;
        case (state)
            IDLE: if (handoff) begin
                state_n = TOP;
                x_n     = '0;
            end
            TOP: if (beat) begin
                state_n = last ? BOT : TOP;
                x_n     = last ? '0 : x + 1'b1;
            end
            BOT: if (beat) begin
                state_n = last ? IDLE : BOT;
                x_n     = last ? '0 : x + 1'b1;
                done_n  = last;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: randomized HUB75 bus stimulus checked against a queue-based row model
module tb_hub75_capture;
    localparam int W  = 64;
    localparam int AB = 5;
    localparam int XW = 6;

    typedef struct {
        int x;
        int y;
        int rgb;
        bit last;
    } beat_t;

    logic          clk = 0;
    logic          reset = 1;
    logic [2:0]    hub_rgb0 = 0, hub_rgb1 = 0;
    logic [AB-1:0] hub_addr = 0;
    logic          hub_blank = 0, hub_latch = 0, hub_sclk = 0;
    logic          pix_valid, pix_ready = 0;
    logic [XW-1:0] pix_x;
    logic [AB:0]   pix_y;
    logic [2:0]    pix_rgb;
    logic          row_done, blank_level, err_len, err_overrun;
    logic          err_clear = 0;

    int    checks = 0, failures = 0, beats = 0, dones = 0, ready_mode = 0;
    beat_t q[$];
    bit    m_len = 0, m_ovr = 0, exp_done = 0, hold = 0;
    int    hval = 0;
    logic [2:0] tp0 [W+8];
    logic [2:0] tp1 [W+8];

    hub75_capture #(.WIDTH(W), .ADDR_BITS(AB), .XW(XW)) dut (
        .clk(clk), .reset(reset), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
        .hub_addr(hub_addr), .hub_blank(hub_blank), .hub_latch(hub_latch), .hub_sclk(hub_sclk),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .row_done(row_done), .blank_level(blank_level),
        .err_len(err_len), .err_overrun(err_overrun), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        pix_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
    end

    // Per-cycle comparison of the stream against the expected beat queue
    always @(negedge clk) begin
        if (reset) begin
            hold = 0;
            exp_done = 0;
        end else begin
            chk(row_done == exp_done, "row_done", row_done, exp_done);
            if (row_done) dones++;
            exp_done = 0;
            if (hold)
                chk(pix_valid && int'({pix_x, pix_y, pix_rgb}) == hval, "stall_hold",
                    int'({pix_valid, pix_x, pix_y, pix_rgb}), hval | (1 << 15));
            if (pix_valid) begin
                if (q.size() == 0)
                    chk(0, "extra_beat", int'({pix_x, pix_y, pix_rgb}), -1);
                else begin
                    chk(int'({pix_x, pix_y, pix_rgb}) == ((q[0].x << 9) | (q[0].y << 3) | q[0].rgb),
                        "beat", int'({pix_x, pix_y, pix_rgb}), (q[0].x << 9) | (q[0].y << 3) | q[0].rgb);
                    if (pix_ready) begin
                        if (q[0].last) exp_done = 1;
                        void'(q.pop_front());
                        beats++;
                    end
                end
            end
            hold = pix_valid && !pix_ready;
            hval = int'({pix_x, pix_y, pix_rgb});
        end
    end

    task automatic fill();
        for (int k = 0; k < W + 8; k++) begin
            tp0[k] = 3'($urandom_range(0, 7));
            tp1[k] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic send_row(input int n, input int a);
        bit pushed;
        pushed = 0;
        hub_addr = AB'(a);
        for (int k = 0; k < n; k++) begin
            hub_rgb0 = tp0[k];
            hub_rgb1 = tp1[k];
            wt(3);
            hub_sclk = 1;
            wt(3);
            hub_sclk = 0;
            wt(1);
        end
        if (n != W) m_len = 1;
        else if (q.size() != 0) m_ovr = 1;
        else begin
            pushed = 1;
            for (int x = 0; x < W; x++) q.push_back('{x, a, int'(tp0[W-1-x]), 0});
            for (int x = 0; x < W; x++) q.push_back('{x, a + (1 << AB), int'(tp1[W-1-x]), x == W - 1});
        end
        hub_latch = 1;
        wt(2);
        if (pushed) chk(!pix_valid, "latency_early", pix_valid, 0);
        wt(1);
        if (pushed) chk(pix_valid, "latency_on", pix_valid, 1);
        hub_latch = 0;
        wt(3);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 5000 && q.size() != 0; i++) wt(1);
        chk(q.size() == 0, "drain", q.size(), 0);
        wt(3);
    endtask

    task automatic chk_err(input string tag);
        chk(err_len == m_len, {tag, "_err_len"}, err_len, m_len);
        chk(err_overrun == m_ovr, {tag, "_err_overrun"}, err_overrun, m_ovr);
    endtask

    task automatic clear_err();
        err_clear = 1;
        wt(1);
        err_clear = 0;
        m_len = 0;
        m_ovr = 0;
        wt(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, d0;
        bit found;
        hub_blank = 1;
        wt(4);
        chk(!pix_valid, "rst_valid", pix_valid, 0);
        chk(pix_x == 0 && pix_y == 0 && pix_rgb == 0, "rst_pix", int'({pix_x, pix_y, pix_rgb}), 0);
        chk(!row_done, "rst_row_done", row_done, 0);
        chk(!blank_level, "rst_blank", blank_level, 0);
        chk_err("rst");
        hub_blank = 0;
        reset = 0;
        wt(3);

        // plain colours, y=5 / y=37
        for (int k = 0; k < W + 8; k++) begin tp0[k] = 3'b001; tp1[k] = 3'b100; end
        b0 = beats; d0 = dones;
        ready_mode = 0;
        send_row(W, 5);
        chk(q.size() == 128, "t1_qsize", q.size(), 128);
        chk(q[0].x == 0 && q[0].y == 5 && q[0].rgb == 1, "t1_first", (q[0].y << 3) | q[0].rgb, 41);
        chk(q[64].x == 0 && q[64].y == 37 && q[64].rgb == 4, "t1_bot", (q[64].y << 3) | q[64].rgb, 300);
        ready_mode = 1;
        wait_empty();
        chk(beats - b0 == 128, "t1_beats", beats - b0, 128);
        chk(dones - d0 == 1, "t1_row_done", dones - d0, 1);
        chk_err("t1");

        // column mapping: only first shifted pixel lit
        for (int k = 0; k < W + 8; k++) begin tp0[k] = 0; tp1[k] = 0; end
        tp0[0] = 3'b111;
        ready_mode = 0;
        send_row(W, 9);
        chk(q[63].rgb == 7 && q[62].rgb == 0 && q[0].rgb == 0, "t2_model", q[63].rgb, 7);
        ready_mode = 1;
        wait_empty();

        // random backpressure, random data, blank asserted
        fill();
        ready_mode = 2;
        hub_blank = 1;
        send_row(W, int'($urandom_range(0, 31)));
        chk(blank_level, "t3_blank_hi", blank_level, 1);
        wait_empty();
        hub_blank = 0;
        wt(3);
        chk(!blank_level, "t3_blank_lo", blank_level, 0);
        fill();
        send_row(W, int'($urandom_range(0, 31)));
        wait_empty();
        chk_err("t3");

        // short and long rows
        ready_mode = 1;
        fill();
        send_row(W - 1, 3);
        chk_err("t4_short");
        clear_err();
        chk_err("t4_clr1");
        fill();
        send_row(W + 6, 4);
        chk_err("t4_long");
        clear_err();
        chk_err("t4_clr2");
        fill();
        send_row(W, 6);
        wait_empty();
        chk_err("t4_after");

        // overrun while previous row still pending
        ready_mode = 0;
        fill();
        send_row(W, 10);
        fill();
        send_row(W, 11);
        chk_err("t5_ovr");
        chk(q.size() == 128 && q[0].y == 10, "t5_pending", q[0].y, 10);
        ready_mode = 1;
        wait_empty();
        chk_err("t5_after");

        // reset in the middle of the top half
        fill();
        d0 = dones;
        send_row(W, 12);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #1;
            found = pix_valid && pix_x == 20 && !pix_y[AB];
        end
        chk(found, "t6_reach_x20", found, 1);
        reset = 1;
        q.delete();
        m_len = 0;
        m_ovr = 0;
        wt(1);
        chk(!pix_valid, "t6_valid", pix_valid, 0);
        chk_err("t6_rst");
        reset = 0;
        wt(10);
        chk(dones == d0, "t6_no_done", dones - d0, 0);
        fill();
        send_row(W, 13);
        wait_empty();
        chk(dones == d0 + 1, "t6_done_after", dones - d0, 1);
        chk_err("t6_end");

        chk(q.size() == 0, "final_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive end of the HUB75 panel interface. Samples an incoming panel bus: rgb0/rgb1, addr, blank, latch and sclk, as produced by the team's LED driver or a chained board.
- Reconstructs each latched row pair and emits it as a pixel write stream with valid/ready handshake, suitable for a framebuffer or checker.
- Used as a loopback monitor on a second PMOD and as a panel emulator in hardware-in-the-loop tests.

Parameters:
- WIDTH, 64, columns per row; number of sclk pulses expected per latch.
- ADDR_BITS, 5, row address width; the panel has 2**ADDR_BITS row pairs.
- XW, 6, width of pix_x; must satisfy 2**XW >= WIDTH.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- reset  in  1  synchronous, active-high reset.
- hub_rgb0  in  3  {B,G,R}, upper half; asynchronous to clk.
- hub_rgb1  in  3  {B,G,R}, lower half; asynchronous.
- hub_addr  in  ADDR_BITS  row pair address; asynchronous.
- hub_blank  in  1  panel blank, high = dark; asynchronous.
- hub_latch  in  1  row latch, rising edge active; asynchronous.
- hub_sclk  in  1  shift clock, rising edge active; asynchronous.
- pix_valid  out  1  pixel beat valid.
- pix_ready  in  1  downstream accepts the beat when high with pix_valid.
- pix_x  out  XW  column of the beat.
- pix_y  out  ADDR_BITS+1  row of the beat.
- pix_rgb  out  3  {B,G,R} of the beat.
- row_done  out  1  one-cycle pulse after the last beat of a row pair is accepted.
- blank_level  out  1  synchronized hub_blank.
- err_len  out  1  sticky: a latch arrived with shift count != WIDTH.
- err_overrun  out  1  sticky: a valid row was dropped because the emitter was busy.
- err_clear  in  1  clears both sticky errors.

Behaviour:

Input sampling:
- Every hub_* input passes through a 2-flop synchronizer.
- Edges are detected on the synchronized copies using a third register stage.
- Data (rgb0, rgb1, addr) is taken from the same synchronized stage as the edge sample.
- Requirement on the source: sclk high and low phases each >= 2 clk periods; data stable >= 2 clk periods around the sclk rise.

Capture:
- Capture line buffer: WIDTH x 6 bits, holding {rgb1, rgb0}.
- Shift count: 0..WIDTH+1. It saturates at WIDTH+1, which is the over-length indication.
- On an sclk rise, shifted pixel k (k = 0 first) is written to column WIDTH-1-k, matching a panel's chained shift register. Writes occur only while count < WIDTH.
- On a latch rise:
  - hub_addr is sampled.
  - If count == WIDTH and the emitter is IDLE: the capture buffer is handed to the emitter, by bank swap of two buffers or by copy. The emitter starts on the next cycle.
  - If count == WIDTH and the emitter is busy: the row is dropped and err_overrun is set.
  - If count != WIDTH: the row is dropped and err_len is set. err_len takes priority; err_overrun is not set.
  - In all three cases count returns to 0.
- An sclk rise and a latch rise detected in the same cycle: the latch is processed first, then the shift becomes pixel k = 0 of the next row.

Emitter FSM, states IDLE, TOP, BOT:
- IDLE -> TOP on handoff. x = 0.
- TOP presents pix_y = {1'b0, addr} and pix_rgb = rgb0[x].
- BOT presents pix_y = {1'b1, addr} and pix_rgb = rgb1[x].
- x advances only on a pix_valid && pix_ready beat.
- TOP -> BOT after the beat with x = WIDTH-1; BOT then starts at x = 0.
- BOT -> IDLE after the beat with x = WIDTH-1. row_done pulses in the cycle after that final beat.
- pix_valid is high exactly in TOP and BOT.
- Once asserted, pix_x, pix_y and pix_rgb stay stable until the beat is accepted.
- Latency: pix_valid rises 1 clk after the latch-edge detect cycle, i.e. about 4 clk after the hub_latch pin rises.
- With pix_ready held high, a row pair takes exactly 2*WIDTH cycles.

Errors and blank:
- err_clear clears both sticky errors. A set event in the same cycle wins over err_clear.
- Blank does not gate capture. blank_level only reports the synchronized state.

Reset:
- pix_valid 0, row_done 0, err_len 0, err_overrun 0, blank_level 0. pix_x, pix_y and pix_rgb are 0.
- FSM returns to IDLE, count to 0, and synchronizers and edge registers to 0.
- Line buffer contents are undefined after reset.
- Reset during emission aborts the row with no row_done. A latch rise already in the synchronizer at reset release is not detected.

Test Plan:
1. 64 sclk pulses with rgb0 = 3'b001 and rgb1 = 3'b100, then latch with addr = 5, pix_ready = 1 -> 128 beats: (x 0..63, y 5, rgb 001), then (x 0..63, y 37, rgb 100); row_done once; no errors.
2. Column mapping: only shift k = 0 carries rgb0 = 3'b111, the rest 0 -> only beat x = 63, y = addr has rgb 111.
3. pix_ready toggled pseudo-randomly at 50% -> all 128 beats delivered in order; outputs held stable while stalled; no duplicates or losses.
4. 63 pulses then latch, and separately 70 pulses then latch -> no beats; err_len = 1 after each; err_clear -> 0; the next 64-pulse row emits normally.
5. pix_ready = 0, row A latched, then full row B latched while A is pending -> err_overrun = 1; after pix_ready = 1 only row A is emitted.
6. Reset asserted mid-TOP at x = 20 -> next cycle pix_valid = 0 and errors = 0; no row_done; a following full row emits correctly from x = 0.
